sub_serial: RTL and testbench

//   Bit-serial two's-complement subtractor: computes A - B one bit per cycle, LSB first.
//   It is the inverse-direction partner of the combinational 4-bit adder in the ALU path.

---
 rtl/sub_serial.sv | 137 +++++++++++++
 tb/tb_sub_serial.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// sub_serial: bit-serial two's-complement subtractor, A - B, one bit per cycle, LSB first.
// Sits behind a ready/valid handshake so a controller can issue a subtraction and collect it later.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous reset, active-high
//   in_valid  - operands valid; accepted when in_valid & in_ready
//   in_ready  - high only while idle
//   A, B      - minuend / subtrahend, signed WIDTH bits
//   ena       - result enable, sampled together with the operands
//   busy      - high while the serial subtraction is in progress
//   out_valid - result available; held until out_ready
//   out_ready - consumer accepts the result when out_valid & out_ready
//   result    - (A-B) mod 2^WIDTH, forced to 0 when the latched ena was 0
//   zero      - unmasked difference is zero; ignores ena
//   overflow  - signed overflow of A-B; ignores ena
module sub_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ena,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  // One extra count value marks the finishing cycle in which the flags are formed.
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              ena_q;
  logic [WIDTH-1:0]  sr_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  result_q;
  logic              zero_q;
  logic              overflow_q;

  logic              a_bit;
  logic              nb_bit;
  logic              diff_bit;
  logic              carry_d;

  // Subtraction as A + ~B + 1: carry starts at 1 and B is inverted bitwise.
  always_comb begin
    a_bit    = a_q[0];
    nb_bit   = ~b_q[0];
    diff_bit = a_bit ^ nb_bit ^ carry_q;
    carry_d  = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      ena_q       <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b1;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            ena_q      <= ena;
            cnt_q      <= '0;
            carry_q    <= 1'b1;
            state_q    <= StBusy;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StBusy: begin
          if (cnt_q != CntW'(WIDTH)) begin
            sr_q    <= {diff_bit, sr_q[WIDTH-1:1]};
            carry_q <= carry_d;
            // Rotate rather than shift so the operands are intact again for the flags.
            a_q     <= {a_q[0], a_q[WIDTH-1:1]};
            b_q     <= {b_q[0], b_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + CntW'(1);
          end else begin
            result_q    <= sr_q & {WIDTH{ena_q}};
            zero_q      <= ~|sr_q;
            overflow_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sr_q[WIDTH-1] != a_q[WIDTH-1]);
            state_q     <= StDone;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH=4): directed corner cases plus randomized
// operands, compared against a signed-arithmetic reference model.
module tb_sub_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         ena = 1'b0;
  logic         busy;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  sub_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ena       (ena),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one subtraction, check latency and flags, optionally stall in DONE for 'hold' cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic e,
                        input int hold);
    int           sd;
    int           lat;
    logic [W-1:0] er;
    logic         ez;
    logic         eo;
    sd = int'($signed(a)) - int'($signed(b));
    er = e ? W'(sd) : '0;
    ez = (a == b);
    eo = (sd > 7) || (sd < -8);

    lat = 0;
    while (!in_ready && lat < 20) begin
      step();
      lat++;
    end
    chk("in_ready_idle", in_ready, 1);

    A = a; B = b; ena = e; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("in_ready_in_busy", in_ready, 0);

    // Junk on the inputs while busy must not disturb the latched operands.
    A = W'($urandom); B = W'($urandom); ena = 1'($urandom);
    in_valid = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    in_valid = 1'b0;
    chk("latency", lat, W + 1);
    chk("result", result, er);
    chk("zero", zero, ez);
    chk("overflow", overflow, eo);
    chk("busy_in_done", busy, 0);

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; A = W'($urandom); B = W'($urandom); ena = 1'b1;
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", result, er);
      chk("hold_zero", zero, ez);
      chk("hold_overflow", overflow, eo);
    end

    // in_valid may still be high here; the handoff edge must not accept it.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
    chk("handoff_busy", busy, 0);
  endtask

  initial begin
    int   lat;
    logic seen;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_overflow", overflow, 0);

    run_op(4'd3, 4'd5, 1'b1, 0);
    run_op(4'd7, 4'hF, 1'b1, 0);
    run_op(4'h8, 4'd1, 1'b1, 0);
    run_op(4'd0, 4'h8, 1'b1, 0);
    run_op(4'd5, 4'd5, 1'b1, 0);
    run_op(4'd3, 4'd1, 1'b0, 0);
    run_op(4'd6, 4'd2, 1'b1, 3);

    // Abort on the second busy cycle.
    lat = 0;
    while (!in_ready && lat < 20) begin
      step();
      lat++;
    end
    A = 4'd3; B = 4'd1; ena = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", seen, 0);
    run_op(4'd2, 4'd2, 1'b1, 0);

    for (int i = 0; i < 25; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
